// File: rtl/vdp_vga_timing_if.sv
// Raster position and timing strobes from vdp_vga_timing to the VDP video FSM.
// master drives the strobes, slave consumes them.
interface vdp_vga_timing_if;
    logic [9:0] px_col;
    logic [9:0] px_row;
    logic       hsync;
    logic       vsync;
    logic       vid_active;
    logic       vid_active0;
    logic       bdr_active;
    logic       sprite_tick;
    logic       last_pixel;
    logic       col_last;
    logic       row_last;

    modport master (
        output px_col, px_row, hsync, vsync, vid_active, vid_active0, bdr_active,
               sprite_tick, last_pixel, col_last, row_last
    );

    modport slave (
        input px_col, px_row, hsync, vsync, vid_active, vid_active0, bdr_active,
              sprite_tick, last_pixel, col_last, row_last
    );
endinterface

// File: rtl/vdp_vga_timing.sv
// Free-running VGA raster generator. Every flag is decoded from the next counter value
// and registered alongside it, so flags line up with the counters they describe.
module vdp_vga_timing #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned H_ACT_START = 64,
    parameter int unsigned H_ACT_LEN   = 512,
    parameter int unsigned V_ACT_START = 48,
    parameter int unsigned V_ACT_LEN   = 384
) (
    input  logic                    pxclk,
    input  logic                    reset_n,
    vdp_vga_timing_if.master        vga
);

    localparam logic [9:0]  HLast       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  VLast       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] VTotal      = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [9:0]  HVis        = 10'(H_VISIBLE);
    localparam logic [9:0]  VVis        = 10'(V_VISIBLE);
    localparam logic [9:0]  HSyncStart  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HSyncEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VSyncStart  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VSyncEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  HActStart   = 10'(H_ACT_START);
    localparam logic [9:0]  HActEnd     = 10'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0]  VActStart   = 10'(V_ACT_START);
    localparam logic [9:0]  VActEnd     = 10'(V_ACT_START + V_ACT_LEN);
    // Sprite scan is requested one row ahead of each active row.
    localparam logic [9:0]  SprRowFirst = 10'(V_ACT_START - 1);
    localparam logic [9:0]  SprRowEnd   = 10'(V_ACT_START + V_ACT_LEN - 1);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic vid_active;
        logic vid_active0;
        logic bdr_active;
        logic sprite_tick;
        logic col_last;
        logic row_last;
        logic last_pixel;
    } flags_t;

    localparam flags_t FlagsReset = '{hsync: 1'b1, vsync: 1'b1, bdr_active: 1'b1, default: 1'b0};

    logic [9:0]  col_q, col_d, row_q, row_d;
    logic [9:0]  col_nx, row_nx;
    logic [10:0] row_inc;
    flags_t      flags_q, flags_d;

    function automatic logic in_window(input logic [9:0] c, input logic [9:0] r);
        return (c >= HActStart) && (c < HActEnd) && (r >= VActStart) && (r < VActEnd);
    endfunction

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == HLast) begin
            col_d = '0;
            row_d = (row_q == VLast) ? '0 : row_q + 10'd1;
        end

        // Position after (col_d,row_d); 11-bit row so the last row + 1 cannot alias.
        row_inc = {1'b0, row_d} + 11'd1;
        col_nx  = col_d + 10'd1;
        row_nx  = row_d;
        if (col_d == HLast) begin
            col_nx = '0;
            row_nx = (row_inc >= VTotal) ? '0 : row_inc[9:0];
        end

        flags_d             = '0;
        flags_d.hsync       = !((col_d >= HSyncStart) && (col_d < HSyncEnd));
        flags_d.vsync       = !((row_d >= VSyncStart) && (row_d < VSyncEnd));
        flags_d.vid_active  = in_window(col_d, row_d);
        flags_d.vid_active0 = in_window(col_nx, row_nx);
        flags_d.bdr_active  = (col_d < HVis) && (row_d < VVis) && !flags_d.vid_active;
        flags_d.sprite_tick = (col_d == HVis) && (row_d >= SprRowFirst) && (row_d < SprRowEnd);
        flags_d.col_last    = (col_d == HVis - 10'd1);
        flags_d.row_last    = (row_d == VVis - 10'd1);
        flags_d.last_pixel  = flags_d.col_last && flags_d.row_last;
    end

    always_ff @(posedge pxclk) begin
        if (!reset_n) begin
            col_q   <= '0;
            row_q   <= '0;
            flags_q <= FlagsReset;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            flags_q <= flags_d;
        end
    end

    assign vga.px_col      = col_q;
    assign vga.px_row      = row_q;
    assign vga.hsync       = flags_q.hsync;
    assign vga.vsync       = flags_q.vsync;
    assign vga.vid_active  = flags_q.vid_active;
    assign vga.vid_active0 = flags_q.vid_active0;
    assign vga.bdr_active  = flags_q.bdr_active;
    assign vga.sprite_tick = flags_q.sprite_tick;
    assign vga.col_last    = flags_q.col_last;
    assign vga.row_last    = flags_q.row_last;
    assign vga.last_pixel  = flags_q.last_pixel;

endmodule

// File: tb/tb_vdp_vga_timing.sv
// Bench for vdp_vga_timing: a full-size instance for reset and early-frame edges, and a
// scaled-down instance for whole-frame counts, sync placement and wrap behaviour.
module tb_vdp_vga_timing;

    typedef struct packed {
        int unsigned hv, hf, hs, hb, vv, vf, vs, vb, has, hal, vas, val;
    } cfg_t;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic hsync, vsync, va, va0, bdr, spr, cl, rl, lp;
    } obs_t;

    typedef struct packed {
        logic id;
        obs_t o;
    } sb_t;

    localparam int unsigned S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int unsigned S_VV = 30, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int unsigned S_HAS = 4, S_HAL = 32, S_VAS = 3, S_VAL = 24;
    localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VV + S_VF + S_VS + S_VB;

    localparam cfg_t CfgBig = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                                has: 64, hal: 512, vas: 48, val: 384};
    localparam cfg_t CfgSml = '{hv: S_HV, hf: S_HF, hs: S_HS, hb: S_HB, vv: S_VV, vf: S_VF,
                                vs: S_VS, vb: S_VB, has: S_HAS, hal: S_HAL, vas: S_VAS,
                                val: S_VAL};

    logic pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    logic rst_n [2] = '{1'b0, 1'b0};

    vdp_vga_timing_if if_big ();
    vdp_vga_timing_if if_sml ();

    vdp_vga_timing u_big (
        .pxclk   (pxclk),
        .reset_n (rst_n[0]),
        .vga     (if_big)
    );

    vdp_vga_timing #(
        .H_VISIBLE   (S_HV),
        .H_FRONT     (S_HF),
        .H_SYNC      (S_HS),
        .H_BACK      (S_HB),
        .V_VISIBLE   (S_VV),
        .V_FRONT     (S_VF),
        .V_SYNC      (S_VS),
        .V_BACK      (S_VB),
        .H_ACT_START (S_HAS),
        .H_ACT_LEN   (S_HAL),
        .V_ACT_START (S_VAS),
        .V_ACT_LEN   (S_VAL)
    ) u_sml (
        .pxclk   (pxclk),
        .reset_n (rst_n[1]),
        .vga     (if_sml)
    );

    obs_t obs [2];
    assign obs[0] = {if_big.px_col, if_big.px_row, if_big.hsync, if_big.vsync,
                     if_big.vid_active, if_big.vid_active0, if_big.bdr_active,
                     if_big.sprite_tick, if_big.col_last, if_big.row_last, if_big.last_pixel};
    assign obs[1] = {if_sml.px_col, if_sml.px_row, if_sml.hsync, if_sml.vsync,
                     if_sml.vid_active, if_sml.vid_active0, if_sml.bdr_active,
                     if_sml.sprite_tick, if_sml.col_last, if_sml.row_last, if_sml.last_pixel};

    int checks = 0;
    int errors = 0;

    int unsigned m_col [2];
    int unsigned m_row [2];
    bit          m_valid [2] = '{1'b0, 1'b0};
    sb_t         sb_q [$];

    function automatic cfg_t cfg_of(input int id);
        return (id == 1) ? CfgSml : CfgBig;
    endfunction

    function automatic bit in_win(input cfg_t c, input int unsigned col, input int unsigned row);
        return (col >= c.has) && (col < c.has + c.hal) && (row >= c.vas) && (row < c.vas + c.val);
    endfunction

    function automatic obs_t model(input cfg_t c, input int unsigned col, input int unsigned row);
        obs_t f;
        int unsigned ht, vt, ncol, nrow;
        ht    = c.hv + c.hf + c.hs + c.hb;
        vt    = c.vv + c.vf + c.vs + c.vb;
        ncol  = (col + 1) % ht;
        nrow  = (ncol == 0) ? (row + 1) % vt : row;
        f.col   = 10'(col);
        f.row   = 10'(row);
        f.hsync = !((col >= c.hv + c.hf) && (col < c.hv + c.hf + c.hs));
        f.vsync = !((row >= c.vv + c.vf) && (row < c.vv + c.vf + c.vs));
        f.va    = in_win(c, col, row);
        f.va0   = in_win(c, ncol, nrow);
        f.bdr   = (col < c.hv) && (row < c.vv) && !f.va;
        f.spr   = (col == c.hv) && (row + 1 >= c.vas) && (row + 1 < c.vas + c.val);
        f.cl    = (col == c.hv - 1);
        f.rl    = (row == c.vv - 1);
        f.lp    = f.cl && f.rl;
        return f;
    endfunction

    // Producer: advance the reference raster on each edge and queue what must appear.
    initial forever begin
        cfg_t c;
        @(posedge pxclk);
        for (int i = 0; i < 2; i++) begin
            c = cfg_of(i);
            if (!rst_n[i]) begin
                m_col[i]   = 0;
                m_row[i]   = 0;
                m_valid[i] = 1'b1;
            end else if (m_valid[i]) begin
                if (m_col[i] == c.hv + c.hf + c.hs + c.hb - 1) begin
                    m_col[i] = 0;
                    m_row[i] = (m_row[i] + 1) % (c.vv + c.vf + c.vs + c.vb);
                end else begin
                    m_col[i] = m_col[i] + 1;
                end
            end
            if (m_valid[i]) sb_q.push_back('{id: 1'(i), o: model(c, m_col[i], m_row[i])});
        end
    end

    // Consumer: compare queued expectations on the falling edge.
    initial forever begin
        sb_t e;
        @(negedge pxclk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (obs[e.id] !== e.o) begin
                errors++;
                $display("FAIL scoreboard dut%0d at (%0d,%0d): got %h required %h",
                         e.id, e.o.col, e.o.row, obs[e.id], e.o);
            end
        end
    end

    task automatic wait_pos(input int id, input int unsigned c, input int unsigned r,
                            input int budget);
        int n;
        n = 0;
        while (!(m_valid[id] && m_col[id] == c && m_row[id] == r) && n < budget) begin
            @(negedge pxclk);
            n++;
        end
        checks++;
        if (!(m_col[id] == c && m_row[id] == r)) begin
            errors++;
            $display("FAIL wait_pos dut%0d: reached (%0d,%0d) required (%0d,%0d)",
                     id, m_col[id], m_row[id], c, r);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pxclk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        wait_pos(0, 300, 5, 10000);
        rst_n[0] = 1'b0;
        repeat (5) @(negedge pxclk);
        checks++;
        if ({if_big.px_col, if_big.px_row} !== 20'd0) begin
            errors++;
            $display("FAIL reset_counters: got (%0d,%0d) required (0,0)",
                     if_big.px_col, if_big.px_row);
        end
        checks++;
        if ({if_big.hsync, if_big.vsync, if_big.vid_active, if_big.vid_active0,
             if_big.bdr_active, if_big.sprite_tick, if_big.col_last, if_big.row_last,
             if_big.last_pixel} !== 9'b110010000) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b%b%b%b required 110010000",
                     if_big.hsync, if_big.vsync, if_big.vid_active, if_big.vid_active0,
                     if_big.bdr_active, if_big.sprite_tick, if_big.col_last,
                     if_big.row_last, if_big.last_pixel);
        end
        rst_n[0] = 1'b1;
        @(negedge pxclk);
        checks++;
        if (if_big.px_col !== 10'd1 || if_big.px_row !== 10'd0) begin
            errors++;
            $display("FAIL reset_release: got (%0d,%0d) required (1,0)",
                     if_big.px_col, if_big.px_row);
        end
    endtask

    task automatic test_window_edges();
        int va_bad, va0_rise, va0_fall, va_rise, va_fall;
        logic p_va, p_va0;
        va_bad = 0;
        wait_pos(0, 0, 47, 40000);
        for (int c = 0; c < 800; c++) begin
            if (if_big.vid_active !== 1'b0) va_bad++;
            if (c == 799) begin
                checks++;
                if (if_big.vid_active0 !== 1'b0) begin
                    errors++;
                    $display("FAIL va0_799_47: got %b required 0", if_big.vid_active0);
                end
            end
            @(negedge pxclk);
        end
        checks++;
        if (va_bad != 0) begin
            errors++;
            $display("FAIL row47_inactive: got %0d active columns required 0", va_bad);
        end
        va0_rise = -1; va0_fall = -1; va_rise = -1; va_fall = -1;
        p_va  = if_big.vid_active;
        p_va0 = if_big.vid_active0;
        for (int c = 0; c < 800; c++) begin
            if (if_big.vid_active0 && !p_va0) va0_rise = c;
            if (!if_big.vid_active0 && p_va0) va0_fall = c;
            if (if_big.vid_active && !p_va) va_rise = c;
            if (!if_big.vid_active && p_va) va_fall = c;
            p_va  = if_big.vid_active;
            p_va0 = if_big.vid_active0;
            @(negedge pxclk);
        end
        checks++;
        if (va0_rise != 63 || va0_fall != 575) begin
            errors++;
            $display("FAIL row48_va0_edges: got rise %0d fall %0d required 63 575",
                     va0_rise, va0_fall);
        end
        checks++;
        if (va_rise != 64 || va_fall != 576) begin
            errors++;
            $display("FAIL row48_va_edges: got rise %0d fall %0d required 64 576",
                     va_rise, va_fall);
        end
    endtask

    task automatic test_frame_counts();
        int t, cl_all, cl_vis, lp_n, spr_n, va_n, bdr_n, excl_bad, out_bad, sp_bad, last_cl;
        int hs_bad, hs_fall_n, vf_c, vf_r, vr_c, vr_r;
        int unsigned spr_fc, spr_fr, spr_lc, spr_lr;
        logic p_hs, p_vs;
        cl_all = 0; cl_vis = 0; lp_n = 0; spr_n = 0; va_n = 0; bdr_n = 0;
        excl_bad = 0; out_bad = 0; sp_bad = 0; last_cl = -1; hs_bad = 0; hs_fall_n = 0;
        vf_c = -1; vf_r = -1; vr_c = -1; vr_r = -1;
        spr_fc = 0; spr_fr = 0; spr_lc = 0; spr_lr = 0;
        rst_n[1] = 1'b0;
        repeat (2) @(negedge pxclk);
        rst_n[1] = 1'b1;
        p_hs = 1'b1;
        p_vs = 1'b1;
        for (t = 0; t < int'(S_HT * S_VT); t++) begin
            if (if_sml.col_last) begin
                cl_all++;
                if (m_row[1] < S_VV) begin
                    cl_vis++;
                    if (last_cl >= 0 && t - last_cl != int'(S_HT)) sp_bad++;
                    last_cl = t;
                end
            end
            if (if_sml.last_pixel) lp_n++;
            if (if_sml.sprite_tick) begin
                if (spr_n == 0) begin
                    spr_fc = m_col[1];
                    spr_fr = m_row[1];
                end
                spr_lc = m_col[1];
                spr_lr = m_row[1];
                spr_n++;
            end
            if (if_sml.vid_active) va_n++;
            if (if_sml.bdr_active) bdr_n++;
            if (if_sml.vid_active && if_sml.bdr_active) excl_bad++;
            if ((m_col[1] >= S_HV || m_row[1] >= S_VV) && (if_sml.vid_active || if_sml.bdr_active))
                out_bad++;
            if (p_hs && !if_sml.hsync) begin
                hs_fall_n++;
                if (m_col[1] != S_HV + S_HF) hs_bad++;
            end
            if (!p_hs && if_sml.hsync && m_col[1] != S_HV + S_HF + S_HS) hs_bad++;
            if (p_vs && !if_sml.vsync) begin
                vf_c = int'(m_col[1]);
                vf_r = int'(m_row[1]);
            end
            if (!p_vs && if_sml.vsync) begin
                vr_c = int'(m_col[1]);
                vr_r = int'(m_row[1]);
            end
            p_hs = if_sml.hsync;
            p_vs = if_sml.vsync;
            @(negedge pxclk);
        end
        checks++;
        if (cl_all != int'(S_VT) || cl_vis != int'(S_VV) || sp_bad != 0) begin
            errors++;
            $display("FAIL col_last_count: got %0d/%0d spacing_bad %0d required %0d/%0d 0",
                     cl_all, cl_vis, sp_bad, S_VT, S_VV);
        end
        checks++;
        if (lp_n != 1) begin
            errors++;
            $display("FAIL last_pixel_count: got %0d required 1", lp_n);
        end
        checks++;
        if (spr_n != int'(S_VAL) || spr_fc != S_HV || spr_fr != S_VAS - 1 ||
            spr_lc != S_HV || spr_lr != S_VAS + S_VAL - 2) begin
            errors++;
            $display("FAIL sprite_ticks: got %0d first (%0d,%0d) last (%0d,%0d) required %0d",
                     spr_n, spr_fc, spr_fr, spr_lc, spr_lr, S_VAL);
        end
        checks++;
        if (va_n != int'(S_HAL * S_VAL) || bdr_n != int'(S_HV * S_VV - S_HAL * S_VAL)) begin
            errors++;
            $display("FAIL active_border_count: got %0d/%0d required %0d/%0d",
                     va_n, bdr_n, S_HAL * S_VAL, S_HV * S_VV - S_HAL * S_VAL);
        end
        checks++;
        if (excl_bad != 0 || out_bad != 0) begin
            errors++;
            $display("FAIL exclusivity: got overlap %0d outside %0d required 0 0",
                     excl_bad, out_bad);
        end
        checks++;
        if (hs_bad != 0 || hs_fall_n != int'(S_VT)) begin
            errors++;
            $display("FAIL hsync_edges: got bad %0d falls %0d required 0 %0d",
                     hs_bad, hs_fall_n, S_VT);
        end
        checks++;
        if (vf_c != 0 || vf_r != int'(S_VV + S_VF) || vr_c != 0 ||
            vr_r != int'(S_VV + S_VF + S_VS)) begin
            errors++;
            $display("FAIL vsync_edges: got fall (%0d,%0d) rise (%0d,%0d) required (0,%0d) (0,%0d)",
                     vf_c, vf_r, vr_c, vr_r, S_VV + S_VF, S_VV + S_VF + S_VS);
        end
    endtask

    task automatic test_wrap();
        wait_pos(1, S_HT - 1, S_VAS - 1, 5000);
        checks++;
        if (if_sml.vid_active0 !== 1'b0) begin
            errors++;
            $display("FAIL va0_line_wrap: got %b required 0", if_sml.vid_active0);
        end
        wait_pos(1, S_HT - 1, S_VT - 1, 5000);
        @(negedge pxclk);
        checks++;
        if (if_sml.px_col !== 10'd0 || if_sml.px_row !== 10'd0 ||
            if_sml.bdr_active !== 1'b1 || if_sml.vsync !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap: got (%0d,%0d) bdr %b vsync %b required (0,0) 1 1",
                     if_sml.px_col, if_sml.px_row, if_sml.bdr_active, if_sml.vsync);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned pos [3][2] = '{'{20, 10}, '{50, 33}, '{7, 0}};
        for (int k = 0; k < 3; k++) begin
            wait_pos(1, pos[k][0], pos[k][1], 5000);
            rst_n[1] = 1'b0;
            @(negedge pxclk);
            rst_n[1] = 1'b1;
            checks++;
            if (if_sml.px_col !== 10'd0 || if_sml.px_row !== 10'd0 || if_sml.hsync !== 1'b1) begin
                errors++;
                $display("FAIL b2b_reset%0d: got (%0d,%0d) hsync %b required (0,0) 1",
                         k, if_sml.px_col, if_sml.px_row, if_sml.hsync);
            end
            @(negedge pxclk);
            checks++;
            if (if_sml.px_col !== 10'd1 || if_sml.px_row !== 10'd0) begin
                errors++;
                $display("FAIL b2b_release%0d: got (%0d,%0d) required (1,0)",
                         k, if_sml.px_col, if_sml.px_row);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window_edges();
        test_frame_counts();
        test_wrap();
        test_back_to_back();
        repeat (2) @(negedge pxclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vdp_vga_timing.md
# vdp_vga_timing

VGA 640x480@60 raster timing generator that sits directly upstream of the VDP video FSM. It runs free on `pxclk` (one VGA pixel per clock) and produces the pixel column and row counters. It also produces the sync, active-window, border, end-of-line/frame and sprite-scan strobes that the FSM pipelines and consumes. The 256x192 TMS9918 display is doubled to a 512x384 window, centred in the 640x480 visible area; the remainder is border.

## Interface
- `H_VISIBLE`, 640, visible columns
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch; line total = 800
- `V_VISIBLE`, 480, visible rows
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch; frame total = 525
- `H_ACT_START`, 64, first active (VDP) column
- `H_ACT_LEN`, 512, active columns
- `V_ACT_START`, 48, first active row
- `V_ACT_LEN`, 384, active rows

- `pxclk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  synchronous, active-low reset
- `px_col`  out  10  current column, 0..799
- `px_row`  out  10  current row, 0..524
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `vid_active`  out  1  (px_col,px_row) is inside the 512x384 active window
- `vid_active0`  out  1  `vid_active` of the next raster position (1 clock early)
- `bdr_active`  out  1  visible (640x480) and not `vid_active`
- `sprite_tick`  out  1  1-clock pulse requesting a sprite scan for the next row
- `last_pixel`  out  1  `col_last` and `row_last`
- `col_last`  out  1  px_col == H_VISIBLE-1 (any row)
- `row_last`  out  1  px_row == V_VISIBLE-1 (any column)

## Operation
- Counters:
  - `px_col` increments every clock and wraps 799 -> 0.
  - On that wrap, `px_row` increments and wraps 524 -> 0.
  - No enable input; the generator runs continuously.
- All outputs are registered. In any cycle, every flag is an exact decode of the `px_col`/`px_row` values presented in that same cycle. No output lags or leads the counters, except `vid_active0`, which is defined as a look-ahead.
- Active window: `vid_active` = 1 iff H_ACT_START <= px_col < H_ACT_START+H_ACT_LEN (64..575) and V_ACT_START <= px_row < V_ACT_START+V_ACT_LEN (48..431).
- `vid_active0`:
  - Equals the `vid_active` value for position (px_col+1, px_row).
  - When px_col = 799, it instead uses position (0, px_row+1 mod 525).
- `bdr_active` = (px_col < 640) and (px_row < 480) and not `vid_active`.
- Sync pulses:
  - `hsync` = 0 iff 656 <= px_col <= 751.
  - `vsync` = 0 iff 490 <= px_row <= 491.
- `sprite_tick`:
  - Asserted for exactly the clock where px_col == H_VISIBLE (640), and only when px_row+1 is an active row, i.e. 47 <= px_row <= 430.
  - This gives 384 ticks per frame.
- Width rules:
  - All comparisons use 10-bit unsigned values; the parameters must keep totals <= 1024.
  - The row look-ahead uses an 11-bit intermediate so that 524+1 cannot alias.
- Reset:
  - While reset_n = 0 at a clock edge, counters load (0,0).
  - All outputs load their decode for (0,0): hsync=1, vsync=1, vid_active=0, vid_active0=0, bdr_active=1, sprite_tick=0, col_last=0, row_last=0, last_pixel=0.
  - Reset asserted mid-frame takes effect on the next edge regardless of position. There is no partial-line completion.

## Timing
- Latency: 0 between counters and flags (same cycle); `vid_active0` leads `vid_active` by exactly 1 clock at both the rising and falling edge of every active line.
- First clock after reset_n rises: px_col=1, px_row=0.
- Line period is 800 clocks; frame period is 420000 clocks.
- `hsync` low 96 clocks per line.
- `vsync` low 1600 clocks per frame: it spans rows 490-491 across all columns and is aligned to column 0.
- `last_pixel` is high for 1 clock per frame, at (639,479).
- Simultaneous events:
  - At (799,524) both counters wrap on the same edge, to (0,0).
  - `vid_active0` at (799,47) = 0, because (0,48) is border.
  - `vid_active0` at (63,48) = 1.

## Test plan
- Reset: hold reset_n=0 for 5 clocks from an arbitrary mid-frame state (e.g. (300,200)) -> outputs equal the (0,0) decode above; px_col=1 one clock after release.
- Full frame count: run 420000 clocks from reset -> exactly one frame; counts are:
  - 480 `col_last` pulses in visible rows (800-clock spacing) and 525 in total;
  - 1 `last_pixel`;
  - 384 `sprite_tick` pulses, the first at (640,47) and the last at (640,430);
  - 196608 `vid_active` clocks;
  - 110592 `bdr_active` clocks.
- Window edges:
  - Row 48: vid_active0 rises at col 63 and vid_active at col 64; vid_active0 falls at col 575 and vid_active at col 576.
  - Row 47 and row 432: vid_active=0 in every column.
- Sync: hsync falls at col 656 and rises at col 752 on every row; vsync falls at (0,490) and rises at (0,492).
- Wrap: at (799,524) -> next cycle (0,0), with bdr_active=1 and vsync=1. At (799,47) -> vid_active0=0.
- Border/visible exclusivity: over a frame, vid_active and bdr_active are never both 1, and both are 0 whenever px_col>=640 or px_row>=480.
